// File: rtl/fft_frame_loader.sv
// fft_frame_loader: serial-to-frame input stage for the 8-point FFT core.
// Samples arrive over valid/ready and are gathered into a ping-pong pair of
// 8-word banks. A full bank is shown on x0..x7 until frame_ack consumes it.
// An in_sof on a mid-frame accept drops the partial frame and restarts at
// index 0.
// Optional feature macro: FFT_LOADER_STATS_EN builds the frame/drop counters.
// When the macro is undefined, both counter ports are tied to zero.
module fft_frame_loader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              misalign,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    logic [1:0][7:0][DATA_W-1:0] mem;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_ptr;
    logic [1:0] bank_full;
    logic [1:0] bank_full_nxt;

    logic accept;
    logic realign;
    logic last;
    logic ack;

    // in_ready and frame_valid depend only on flops.
    assign in_ready    = !bank_full[wr_bank];
    assign frame_valid = bank_full[rd_bank];

    assign accept  = in_valid & in_ready;
    assign realign = accept & in_sof & (wr_ptr != 3'd0);
    assign last    = accept & !realign & (wr_ptr == 3'd7);
    assign ack     = frame_ack & bank_full[rd_bank];

    assign x0 = mem[rd_bank][0];
    assign x1 = mem[rd_bank][1];
    assign x2 = mem[rd_bank][2];
    assign x3 = mem[rd_bank][3];
    assign x4 = mem[rd_bank][4];
    assign x5 = mem[rd_bank][5];
    assign x6 = mem[rd_bank][6];
    assign x7 = mem[rd_bank][7];

    // Fill/drain flags. An accept needs the write bank empty, and an ack needs
    // the read bank full. A completion and an ack in the same cycle therefore
    // always hit different banks, so both updates can apply together.
    always_comb begin
        bank_full_nxt = bank_full;
        if (last)
            bank_full_nxt[wr_bank] = 1'b1;
        if (ack)
            bank_full_nxt[rd_bank] = 1'b0;
    end

    // Bank storage, pointers and the misalign pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem       <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= 3'd0;
            bank_full <= 2'b00;
            misalign  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            misalign  <= realign;
            if (accept)
                mem[wr_bank][realign ? 3'd0 : wr_ptr] <= in_data;
            if (realign)
                wr_ptr <= 3'd1;
            else if (accept)
                wr_ptr <= wr_ptr + 3'd1;   // the pointer wraps from 7 to 0 on its own
            if (last)
                wr_bank <= ~wr_bank;
            if (ack)
                rd_bank <= ~rd_bank;
        end
    end

`ifdef FFT_LOADER_STATS_EN
    // Statistics counters. They are 16 bits wide and wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (last)
                frame_cnt <= frame_cnt + 16'd1;
            if (realign)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = 16'd0;
    assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: a directed vector table, hand-written corner
// sequences, and a random run. Every cycle is checked against a frame-queue
// reference model.
module tb_fft_frame_loader;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic              frame_valid;
    logic              frame_ack;
    logic              misalign;
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;

    fft_frame_loader #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .misalign(misalign),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [7:0][31:0] frame_t;
    logic [7:0][31:0] xs;
    assign xs = {x7, x6, x5, x4, x3, x2, x1, x0};

`ifdef FFT_LOADER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the frames waiting downstream (at most two), the
    // partial frame being assembled, and the event counts.
    frame_t mq[$];
    frame_t cur;
    int     mptr;
    int     mfcnt;
    int     mdcnt;
    logic   mmis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] st(input int v);
        return STATS ? 16'(v) : 16'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        cur   = '0;
        mptr  = 0;
        mfcnt = 0;
        mdcnt = 0;
        mmis  = 1'b0;
    endtask

    task automatic check_model();
        chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, mq.size() > 0});
        chk("misalign", {31'd0, misalign}, {31'd0, mmis});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, st(mfcnt)});
        chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, st(mdcnt)});
        if (mq.size() > 0)
            for (int k = 0; k < 8; k++)
                chk($sformatf("x%0d", k), xs[k], mq[0][k]);
    endtask

    // Apply one cycle of inputs, advance the model across the edge, and then
    // check on the falling edge.
    task automatic cycle(input logic v, input logic s, input logic [31:0] d, input logic a);
        logic acc, ak;
        frame_t f;
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        frame_ack = a;
        acc = v && (mq.size() < 2);
        ak  = a && (mq.size() > 0);
        @(posedge clk);
        mmis = acc && s && (mptr != 0);
        if (ak)
            f = mq.pop_front();
        if (acc) begin
            if (s && mptr != 0) begin
                cur[0] = d;
                mptr   = 1;
                mdcnt  = (mdcnt + 1) % 65536;
            end else begin
                cur[mptr] = d;
                if (mptr == 7) begin
                    mq.push_back(cur);
                    mfcnt = (mfcnt + 1) % 65536;
                    mptr  = 0;
                end else begin
                    mptr++;
                end
            end
        end
        @(negedge clk);
        check_model();
    endtask

    // Assert reset in the middle of a cycle, confirm the outputs clear
    // asynchronously, then release reset.
    task automatic do_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        frame_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst drop_cnt", {16'd0, drop_cnt}, 32'd0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rst x%0d", k), xs[k], 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v, s, a;
        logic [31:0] d;
        logic        e_rdy, e_fv, e_mis;
        logic [31:0] e_x0, e_x7;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int mc;
        logic [31:0] first2;
        // One frame of 0x10..0x17, one idle cycle, then an ack.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{v: 1'b1, s: (i == 0), a: 1'b0, d: 32'h10 + 32'(i),
                       e_rdy: 1'b1, e_fv: (i == 7), e_mis: 1'b0,
                       e_x0: 32'h10, e_x7: 32'h17, e_fc: (i == 7) ? 16'd1 : 16'd0};
        tbl[8] = '{v: 1'b0, s: 1'b0, a: 1'b0, d: 32'h0, e_rdy: 1'b1, e_fv: 1'b1,
                   e_mis: 1'b0, e_x0: 32'h10, e_x7: 32'h17, e_fc: 16'd1};
        tbl[9] = '{v: 1'b0, s: 1'b0, a: 1'b1, d: 32'h0, e_rdy: 1'b1, e_fv: 1'b0,
                   e_mis: 1'b0, e_x0: 32'h10, e_x7: 32'h17, e_fc: 16'd1};

        rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_reset();
        check_model();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a);
            chk($sformatf("tbl%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d frame_valid", i), {31'd0, frame_valid}, {31'd0, tbl[i].e_fv});
            chk($sformatf("tbl%0d misalign", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
            chk($sformatf("tbl%0d frame_cnt", i), {16'd0, frame_cnt}, {16'd0, STATS ? tbl[i].e_fc : 16'd0});
            if (tbl[i].e_fv) begin
                chk($sformatf("tbl%0d x0", i), x0, tbl[i].e_x0);
                chk($sformatf("tbl%0d x7", i), x7, tbl[i].e_x7);
            end
        end

        // 24 samples with no ack: input back-pressure after two frames
        for (int i = 0; i < 24; i++)
            cycle(1'b1, (i % 8) == 0, 32'h100 + 32'(i), 1'b0);
        chk("full in_ready", {31'd0, in_ready}, 32'd0);
        chk("full x0 holds frame1", x0, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("after ack frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("after ack x0 frame2", x0, 32'h108);
        chk("after ack in_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Mid-frame SOF realignment
        mc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i == 0, 32'h200 + 32'(i), 1'b0);
            mc += int'(misalign);
        end
        cycle(1'b1, 1'b1, 32'hAA, 1'b0);
        mc += int'(misalign);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, 32'h300 + 32'(i), 1'b0);
            mc += int'(misalign);
        end
        chk("misalign pulses", 32'(mc), 32'd1);
        chk("realign x0", x0, 32'hAA);
        chk("realign x7", x7, 32'h306);
        chk("realign drop_cnt", {16'd0, drop_cnt}, {16'd0, st(1)});
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // A completion and an ack land on the same edge
        for (int i = 0; i < 8; i++)
            cycle(1'b1, i == 0, 32'h400 + 32'(i), 1'b0);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, i == 0, 32'h500 + 32'(i), 1'b0);
        chk("pre-swap x0", x0, 32'h400);
        cycle(1'b1, 1'b0, 32'h507, 1'b1);
        first2 = 32'h500;
        chk("swap frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("swap x0", x0, first2);
        chk("swap x7", x7, 32'h507);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++)
            cycle(1'b1, i == 0, 32'h600 + 32'(i), 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 32'h50 + 32'(i), 1'b0);
        chk("post-rst frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("post-rst x0", x0, 32'h50);
        chk("post-rst frame_cnt", {16'd0, frame_cnt}, {16'd0, st(1)});
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic compared with the model
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom_range(0, 2) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
